// File: rtl/gray2bin_sync_if.sv
// Gray-count receive bus: source drives Gray/Clr, decoder returns the
// decoded count and per-transition event flags.
interface gray2bin_sync_if #(
   parameter int DATA_WID = 4
);
   logic [DATA_WID-1:0] Gray;
   logic                Clr;
   logic [DATA_WID-1:0] Bin;
   logic                Valid;
   logic                Step;
   logic                Up;
   logic [DATA_WID-1:0] Delta;
   logic                Err;
   logic                ErrSticky;

   modport master (
      output Gray, Clr,
      input  Bin, Valid, Step, Up, Delta, Err, ErrSticky
   );

   modport slave (
      input  Gray, Clr,
      output Bin, Valid, Step, Up, Delta, Err, ErrSticky
   );
endinterface

// File: rtl/gray2bin_sync.sv
// Synchronizes an async Gray count, decodes to binary and flags step/jump events.
// Latency SYNC_STAGES+1 edges from Gray to Bin; no backpressure, one sample per cycle.
module gray2bin_sync #(
   parameter int DATA_WID    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic           Clk,
   input  logic           Rst,
   gray2bin_sync_if.slave bus
);

   typedef logic [DATA_WID-1:0] word_t;
   localparam int CNT_WID = $clog2(SYNC_STAGES + 1);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("gray2bin_sync: SYNC_STAGES must be in 2..4");
   end

   function automatic word_t g2b(input word_t g);
      word_t b;
      b[DATA_WID-1] = g[DATA_WID-1];
      for (int i = DATA_WID - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [SYNC_STAGES-1:0][DATA_WID-1:0] sync_q, sync_d;
   word_t                                g_prev_q, g_prev_d;
   word_t                                bin_q, bin_d;
   word_t                                delta_q, delta_d;
   logic [CNT_WID-1:0]                   prime_cnt_q, prime_cnt_d;
   logic                                 valid_q, valid_d;
   logic                                 step_q, step_d;
   logic                                 up_q, up_d;
   logic                                 err_q, err_d;
   logic                                 sticky_q, sticky_d;

   word_t g_cur;
   word_t diff;
   word_t delta_calc;

   assign g_cur = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d      = sync_q;
      sync_d[0]   = bus.Gray;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end

      g_prev_d    = g_cur;
      bin_d       = g2b(g_cur);

      // Valid rises once the chain has been refilled with real samples.
      prime_cnt_d = prime_cnt_q;
      if (prime_cnt_q != CNT_WID'(SYNC_STAGES)) begin
         prime_cnt_d = prime_cnt_q + CNT_WID'(1);
      end
      valid_d     = valid_q | (prime_cnt_q == CNT_WID'(SYNC_STAGES));

      diff        = g_cur ^ g_prev_q;
      delta_calc  = g2b(g_cur) - g2b(g_prev_q);

      // Events gated by Valid so the reset-to-first-sample jump is ignored.
      step_d      = valid_q & ($countones(diff) == 1);
      err_d       = valid_q & ($countones(diff) > 1);

      delta_d     = delta_q;
      if (step_d || err_d) begin
         delta_d = delta_calc;
      end

      up_d        = up_q;
      if (step_d) begin
         up_d = (delta_calc == word_t'(1));
      end

      sticky_d    = sticky_q;
      if (err_d) begin
         sticky_d = 1'b1;
      end else if (bus.Clr) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         sync_q      <= '0;
         g_prev_q    <= '0;
         bin_q       <= '0;
         delta_q     <= '0;
         prime_cnt_q <= '0;
         valid_q     <= 1'b0;
         step_q      <= 1'b0;
         up_q        <= 1'b0;
         err_q       <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         g_prev_q    <= g_prev_d;
         bin_q       <= bin_d;
         delta_q     <= delta_d;
         prime_cnt_q <= prime_cnt_d;
         valid_q     <= valid_d;
         step_q      <= step_d;
         up_q        <= up_d;
         err_q       <= err_d;
         sticky_q    <= sticky_d;
      end
   end

   assign bus.Bin       = bin_q;
   assign bus.Valid     = valid_q;
   assign bus.Step      = step_q;
   assign bus.Up        = up_q;
   assign bus.Delta     = delta_q;
   assign bus.Err       = err_q;
   assign bus.ErrSticky = sticky_q;

endmodule
